// File: rtl/main_mem_responder.sv
// Backing-store responder for the cache miss interface: fixed-latency block reads and writes,
// one word per cycle. Define MEM_CRITICAL_WORD_FIRST_EN to start read bursts at the requested word.
module main_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  output logic              ReqReady,
  input  logic              WrValid,
  input  logic [DATA_W-1:0] WrData,
  output logic              RdValid,
  output logic [DATA_W-1:0] RdData,
  output logic              RdLast,
  output logic              WrAck
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam int CNT_W = 4;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_DATA,
    WR_WAIT
  } state_t;

  state_t             state;
  logic [BLK_W-1:0]   blk;
  logic [OFF_W-1:0]   rd_off;
  logic [OFF_W-1:0]   wr_off;
  logic [OFF_W-1:0]   beat;
  logic [CNT_W-1:0]   wait_cnt;

  logic [OFF_W-1:0]   start_off;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  rd_word;
  logic               wr_en;
  logic               last_beat;

  // Words are stored XORed with their own address, so the all-zero power-up
  // contents of the array read back as the identity image mem[a] = a.
  logic [DATA_W-1:0]  store [DEPTH];

  assign start_off = ReqAddr[OFF_W-1:0] & {OFF_W{CRIT_FIRST}};
  assign rd_addr   = {blk, rd_off};
  assign wr_addr   = {blk, wr_off};
  assign rd_word   = store[rd_addr] ^ DATA_W'(rd_addr);
  assign wr_en     = (state == WR_DATA) && WrValid && !Reset;
  assign last_beat = (beat == OFF_W'(BLOCK_WORDS - 1));

  // NOTE: the storage array has no reset branch; clearing it would need a
  // flop-based array and would destroy data that must survive a reset.
  always_ff @(posedge Clk) begin
    if (wr_en) store[wr_addr] <= WrData ^ DATA_W'(wr_addr);
  end

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values, matching the hardware they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      ReqReady <= 1'b1;
      RdValid  <= 1'b0;
      RdData   <= '0;
      RdLast   <= 1'b0;
      WrAck    <= 1'b0;
      blk      <= '0;
      rd_off   <= '0;
      wr_off   <= '0;
      beat     <= '0;
      wait_cnt <= '0;
    end else begin
      WrAck <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            blk      <= ReqAddr[ADDR_W-1:OFF_W];
            rd_off   <= start_off;
            wr_off   <= '0;
            beat     <= '0;
            wait_cnt <= '0;
            ReqReady <= 1'b0;
            state    <= ReqWrite ? WR_DATA : RD_WAIT;
          end
        end

        // Holds one extra cycle beyond LATENCY because the first word is
        // registered on the way out of this state.
        RD_WAIT: begin
          if (wait_cnt == CNT_W'(LATENCY)) begin
            state   <= RD_BURST;
            RdValid <= 1'b1;
            RdData  <= rd_word;
            RdLast  <= last_beat;
            rd_off  <= rd_off + 1'b1;
            beat    <= beat + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RD_BURST: begin
          if (RdLast) begin
            state    <= IDLE;
            ReqReady <= 1'b1;
            RdValid  <= 1'b0;
            RdData   <= '0;
            RdLast   <= 1'b0;
          end else begin
            RdData <= rd_word;
            RdLast <= last_beat;
            rd_off <= rd_off + 1'b1;
            beat   <= beat + 1'b1;
          end
        end

        WR_DATA: begin
          if (WrValid) begin
            wr_off <= wr_off + 1'b1;
            if (wr_off == OFF_W'(BLOCK_WORDS - 1)) begin
              state    <= WR_WAIT;
              wait_cnt <= '0;
            end
          end
        end

        WR_WAIT: begin
          if (wait_cnt == CNT_W'(LATENCY - 1)) begin
            state    <= IDLE;
            ReqReady <= 1'b1;
            WrAck    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          ReqReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed scenarios plus randomized traffic
// checked cycle by cycle against a word-array model of the backing store.
module tb_main_mem_responder;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int BW     = 4;
  localparam int LAT    = 3;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              ReqValid;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic              ReqReady;
  logic              WrValid;
  logic [DATA_W-1:0] WrData;
  logic              RdValid;
  logic [DATA_W-1:0] RdData;
  logic              RdLast;
  logic              WrAck;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  logic [DATA_W-1:0] wdata   [BW];

  main_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW), .LATENCY(LAT)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqReady(ReqReady),
    .WrValid(WrValid), .WrData(WrData),
    .RdValid(RdValid), .RdData(RdData), .RdLast(RdLast), .WrAck(WrAck)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic noise();
    WrValid = 1'($urandom_range(0, 1));
    WrData  = 8'($urandom);
  endtask

  function automatic int first_off(input int addr);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    return addr % BW;
`else
    return 0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ReqReady, 1);
    check({tag, "_rdvalid"}, RdValid, 0);
    check({tag, "_rddata"}, RdData, 0);
    check({tag, "_rdlast"}, RdLast, 0);
    check({tag, "_wrack"}, WrAck, 0);
  endtask

  // Presents a request and returns just after the accepting edge.
  task automatic accept(input logic wr, input int addr, output bit ok);
    int budget = 0;
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = 8'(addr);
    while (ReqReady !== 1'b1 && budget < 100) begin
      noise();
      tick();
      budget++;
    end
    ok = (budget < 100);
    if (!ok) begin
      check("accept_timeout", 0, 1);
      ReqValid = 1'b0;
      return;
    end
    noise();
    tick();
    check("accept_ready_drop", ReqReady, 0);
  endtask

  // abort_at >= 0 asserts Reset on the edge that would deliver word abort_at.
  task automatic do_read(input int addr, input bit hold, input int abort_at);
    bit ok;
    int base, start, j;
    accept(1'b0, addr, ok);
    if (!ok) return;
    if (!hold) ReqValid = 1'b0;
    base  = addr & ~(BW - 1);
    start = first_off(addr);
    for (int i = 1; i <= LAT + BW + 1; i++) begin
      if (abort_at >= 0 && i == LAT + 1 + abort_at) begin
        ReqValid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset_outputs("rd_abort");
        return;
      end
      noise();
      tick();
      j = i - LAT - 1;
      if (j >= 0 && j < BW) begin
        check("rd_valid", RdValid, 1);
        check("rd_data", RdData, ref_mem[base + (start + j) % BW]);
      end else begin
        check("rd_valid", RdValid, 0);
        check("rd_data_idle", RdData, 0);
      end
      check("rd_last", RdLast, (j == BW - 1) ? 1 : 0);
      check("rd_ready", ReqReady, (i == LAT + BW + 1) ? 1 : 0);
      check("rd_wrack", WrAck, 0);
    end
  endtask

  // Writes wdata[] to the block; gap_after inserts one idle beat after that word.
  task automatic do_write(input int addr, input int gap_pct, input int gap_after, input int abort_after);
    bit ok, give, gap_done;
    int base, k, cycles;
    accept(1'b1, addr, ok);
    if (!ok) return;
    ReqValid = 1'b0;
    base = addr & ~(BW - 1);
    k = 0;
    cycles = 0;
    gap_done = 1'b0;
    while (k < BW && cycles < 200) begin
      if (abort_after >= 0 && k == abort_after) begin
        WrValid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset_outputs("wr_abort");
        return;
      end
      give = ($urandom_range(0, 99) >= gap_pct);
      if (k == gap_after + 1 && !gap_done) begin
        give = 1'b0;
        gap_done = 1'b1;
      end
      WrValid = give;
      WrData  = give ? wdata[k] : 8'($urandom);
      tick();
      if (give) begin
        ref_mem[base + k] = wdata[k];
        k++;
      end
      check("wr_ready", ReqReady, 0);
      check("wr_ack_early", WrAck, 0);
      check("wr_rdvalid", RdValid, 0);
      cycles++;
    end
    if (k < BW) begin
      check("wr_timeout", 0, 1);
      return;
    end
    for (int i = 1; i <= LAT; i++) begin
      noise();
      tick();
      check("wr_ack", WrAck, (i == LAT) ? 1 : 0);
      check("wr_ready_ret", ReqReady, (i == LAT) ? 1 : 0);
    end
  endtask

  task automatic idle_cycle();
    ReqValid = 1'b0;
    noise();
    tick();
    check("idle_ready", ReqReady, 1);
    check("idle_rdvalid", RdValid, 0);
    check("idle_wrack", WrAck, 0);
  endtask

  task automatic rand_wdata();
    for (int i = 0; i < BW; i++) wdata[i] = 8'($urandom);
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ref_mem[a] = 8'(a);
    Reset = 1'b1;
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
    ReqAddr = '0;
    WrValid = 1'b0;
    WrData = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    Reset = 1'b0;
    idle_cycle();

    do_read(8'h12, 1'b0, -1);

    for (int i = 0; i < BW; i++) wdata[i] = 8'(8'hA0 + i);
    do_write(8'h20, 0, 1, -1);
    idle_cycle();
    do_read(8'h23, 1'b0, -1);

    do_read(8'h40, 1'b1, -1);
    do_read(8'h40, 1'b0, -1);

    wdata[0] = 8'h5A;
    wdata[1] = 8'h5B;
    do_write(8'h30, 0, -1, 2);
    idle_cycle();
    do_read(8'h30, 1'b0, -1);

    do_read(8'h50, 1'b0, 2);
    idle_cycle();

    for (int t = 0; t < 60; t++) begin
      int addr;
      int abort;
      addr = $urandom_range(0, (1 << ADDR_W) - 1);
      abort = ($urandom_range(0, 9) == 0) ? $urandom_range(0, BW - 1) : -1;
      if ($urandom_range(0, 1) == 1) begin
        rand_wdata();
        do_write(addr, 30, -1, abort);
      end else begin
        do_read(addr, 1'b0, abort);
      end
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
